coin_payout: RTL

Change-payout controller for the vending datapath. The vending FSM takes coins in and flags when change is owed. This block is the outbound end. It takes a change amount and drives the coin hopper's per-denomination eject solenoids one coin at a time. After each eject it waits for the hopper exit sensor to confirm the coin. It reports completion, or an error if the payout cannot be finished.

---
 rtl/coin_payout_if.sv | 30 +++
 rtl/coin_payout.sv | 119 +++++++++++
 2 files changed

// File: rtl/coin_payout_if.sv
// Hopper-side bundle for the change-payout controller: payout request, tube
// status, exit sensor, eject solenoids and payout status.
interface coin_payout_if #(
  parameter int AMT_W = 6
);
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             q_empty;
  logic             d_empty;
  logic             n_empty;
  logic             coin_sense;
  logic             eject_q;
  logic             eject_d;
  logic             eject_n;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] remain;
  logic [AMT_W-1:0] paid;

  modport master (
    output req, amount, q_empty, d_empty, n_empty, coin_sense,
    input  eject_q, eject_d, eject_n, busy, done, err, remain, paid
  );

  modport slave (
    input  req, amount, q_empty, d_empty, n_empty, coin_sense,
    output eject_q, eject_d, eject_n, busy, done, err, remain, paid
  );
endinterface

// File: rtl/coin_payout.sv
// Change-payout controller: greedily ejects quarters/dimes/nickels one at a
// time, waiting for the exit sensor after each coin, and flags done or err.
module coin_payout #(
  parameter int AMT_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  coin_payout_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJ_Q, S_EJ_D, S_EJ_N, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AMT_W-1:0] r_remain;
  logic [AMT_W-1:0] r_paid;
  logic [2:0]       r_val;
  logic [TW-1:0]    r_timer;
  logic [1:0]       w_pick;

  // Pick code: 1 = quarter, 2 = dime, 3 = nickel, 0 = nothing payable.
  function automatic logic [1:0] coin_pick(input logic [AMT_W-1:0] rem,
                                           input logic qe, input logic de,
                                           input logic ne);
    logic [1:0] pick;
    pick = 2'd0;
    if (rem >= AMT_W'(5) && !qe)      pick = 2'd1;
    else if (rem >= AMT_W'(2) && !de) pick = 2'd2;
    else if (rem >= AMT_W'(1) && !ne) pick = 2'd3;
    return pick;
  endfunction

  function automatic logic [2:0] coin_val(input logic [1:0] pick);
    logic [2:0] v;
    case (pick)
      2'd1:    v = 3'd5;
      2'd2:    v = 3'd2;
      2'd3:    v = 3'd1;
      default: v = 3'd0;
    endcase
    return v;
  endfunction

  always_comb w_pick = coin_pick(r_remain, bus.q_empty, bus.d_empty, bus.n_empty);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req) w_next = (bus.amount == '0) ? S_DONE : S_SELECT;
      S_SELECT: begin
        case (w_pick)
          2'd1:    w_next = S_EJ_Q;
          2'd2:    w_next = S_EJ_D;
          2'd3:    w_next = S_EJ_N;
          default: w_next = S_ERR;
        endcase
      end
      S_EJ_Q, S_EJ_D, S_EJ_N: w_next = S_WAIT;
      S_WAIT: begin
        // A coin confirmed on the last timeout cycle still counts as paid.
        if (bus.coin_sense)
          w_next = (r_remain == AMT_W'(r_val)) ? S_DONE : S_SELECT;
        else if (r_timer == TW'(TIMEOUT - 1))
          w_next = S_ERR;
      end
      S_DONE, S_ERR: w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (r_state != S_IDLE);
    bus.eject_q = (r_state == S_EJ_Q);
    bus.eject_d = (r_state == S_EJ_D);
    bus.eject_n = (r_state == S_EJ_N);
    bus.done    = (r_state == S_DONE);
    bus.err     = (r_state == S_ERR);
    bus.remain  = r_remain;
    bus.paid    = r_paid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remain <= '0;
      r_paid   <= '0;
      r_val    <= '0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_remain <= bus.amount;
            r_paid   <= '0;
          end
        end
        S_SELECT: r_val <= coin_val(w_pick);
        S_EJ_Q, S_EJ_D, S_EJ_N: r_timer <= '0;
        S_WAIT: begin
          if (bus.coin_sense) begin
            r_remain <= r_remain - AMT_W'(r_val);
            r_paid   <= r_paid + AMT_W'(r_val);
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
